mem_read_mux: RTL and testbench
===============================

Name: mem_read_mux

Overview:
- Bus-side steering stage directly downstream of the boot ROM, between the CPU memory port and the ROM and RAM.
- Latches each CPU access and probes the boot ROM through its select flag. Returns ROM data when the ROM claims the address; otherwise runs a ready-handshake cycle to RAM.
- Returns one registered data word and a one-cycle acknowledge to the CPU.
- Writes always go to RAM. The ROM shadows reads only.

Parameters:
- ADDR_W, 15, CPU/ROM/RAM address width (field + 12-bit address).
- DATA_W, 12, word width.
- TIMEOUT, 15, max cycles ram_rd/ram_wr is held waiting for ram_ready before abort.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_addr  in  ADDR_W  access address.
- cpu_rd  in  1  read request, level, held until cpu_ack.
- cpu_wr  in  1  write request, level, held until cpu_ack.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_ack  out  1  one-cycle access-complete pulse.
- cpu_err  out  1  one-cycle pulse with cpu_ack on RAM timeout.
- rom_addr  out  ADDR_W  latched address to boot ROM.
- rom_rd  out  1  ROM read strobe.
- rom_data  in  DATA_W  ROM read data.
- rom_selected  in  1  ROM claims rom_addr.
- ram_addr  out  ADDR_W  latched address to RAM.
- ram_wdata  out  DATA_W  latched write data.
- ram_rd  out  1  RAM read request.
- ram_wr  out  1  RAM write request.
- ram_rdata  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM completes the access this cycle.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: cpu_rdata, cpu_ack, cpu_err, rom_rd, ram_rd, ram_wr, latched addr/data, wait counter.
  - Mid-access reset drops ram_rd/ram_wr/rom_rd immediately and produces no ack.
- IDLE:
  - On cpu_rd or cpu_wr, latch cpu_addr and cpu_wdata, record the op, go to PROBE.
  - cpu_rd and cpu_wr both high: treated as read.
- PROBE (exactly 1 cycle), driven from the latched address:
  - Read: rom_rd=1. If rom_selected, capture rom_data into cpu_rdata and go to DONE. Else go to RAM_RD.
  - Write: rom_rd=0 and rom_selected is ignored; go to RAM_WR.
  - rom_rd is high for exactly one cycle per read access. This keeps ROM self-deactivation counting exact.
- RAM_RD / RAM_WR:
  - ram_rd or ram_wr held high. Wait counter increments each cycle.
  - On ram_ready: capture ram_rdata into cpu_rdata on reads (write leaves cpu_rdata unchanged), drop the request, go to DONE.
  - If the counter reaches TIMEOUT with no ready: drop the request, cpu_rdata=7777 (read only), set error flag, go to DONE.
  - ram_ready outside these states is ignored.
- DONE (1 cycle): cpu_ack=1, cpu_err=error flag. Clear counter and flag, go to RELEASE.
- RELEASE: wait until cpu_rd=0 and cpu_wr=0, then go to IDLE. A request held past ack never produces a second access.
- cpu_rdata holds its value between acks.
- Latency, counting the request-sampled edge as cycle 0:
  - ROM read: ack in cycle 2.
  - RAM access with ram_ready on the first RAM cycle: ack in cycle 3.
  - Each extra wait cycle adds 1.
- rom_addr and ram_addr always equal the latched address; they change only on IDLE acceptance.
- Counter width is clog2(TIMEOUT+1). A counter equal to TIMEOUT aborts; there is no wrap.
- rom_selected changing during RAM states has no effect.

Test Plan:
- ROM read: after reset, read 07400, ROM selected with data 7240 -> ram_rd never asserted; cpu_ack at cycle 2; cpu_rdata=7240; rom_rd high exactly 1 cycle.
- RAM read with wait: read 00200, rom_selected=0, ram_ready after 3 cycles, ram_rdata=1234 -> ram_rd high 3 cycles; ack at cycle 5; cpu_rdata=1234; cpu_err=0.
- Write shadowing: write 5555 to 07400 while rom_selected=1 -> rom_rd stays 0; ram_wr with ram_addr=07400, ram_wdata=5555; ack; cpu_rdata unchanged.
- Timeout: read 00100, ram_ready never asserts -> ram_rd high exactly 15 cycles; ack with cpu_err=1; cpu_rdata=7777. The next access completes normally.
- Held request: cpu_rd held 10 cycles after ack -> exactly one ack. Dropping then re-asserting cpu_rd starts a new access.
- Reset mid-access: assert reset during RAM_RD wait -> ram_rd=0 in the same cycle, no ack, all outputs 0. After release, a ROM read of 07401 returns 1224.

Source files
------------

// File: rtl/mem_read_mux.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_mux
// Description : Steers latched CPU accesses to the boot ROM (reads it claims)
//               or to RAM through a ready handshake with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_mux #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_selected,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PROBE   = 3'd1;
    localparam logic [2:0] c_ST_RAM_RD  = 3'd2;
    localparam logic [2:0] c_ST_RAM_WR  = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;
    localparam logic [2:0] c_ST_RELEASE = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic              w_accept;
    logic              w_load_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_set_err;
    logic [CNT_W-1:0]  w_cnt_inc_val;

    assign w_cnt_inc_val = r_cnt + CNT_W'(1);

    assign cpu_rdata = r_rdata;
    assign rom_addr  = r_addr;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_load_rdata = 1'b0;
        w_rdata_nxt  = '0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_set_err    = 1'b0;
        rom_rd       = 1'b0;
        ram_rd       = 1'b0;
        ram_wr       = 1'b0;
        cpu_ack      = 1'b0;
        cpu_err      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu_rd || cpu_wr) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_PROBE;
                end
            end
            c_ST_PROBE: begin
                // Writes never strobe the ROM so its read-count stays exact
                if (r_is_rd) begin
                    rom_rd = 1'b1;
                    if (rom_selected) begin
                        w_load_rdata = 1'b1;
                        w_rdata_nxt  = rom_data;
                        w_state_nxt  = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_RAM_RD;
                    end
                end else begin
                    w_state_nxt = c_ST_RAM_WR;
                end
            end
            c_ST_RAM_RD: begin
                ram_rd    = 1'b1;
                w_cnt_inc = 1'b1;
                if (ram_ready) begin
                    w_load_rdata = 1'b1;
                    w_rdata_nxt  = ram_rdata;
                    w_state_nxt  = c_ST_DONE;
                end else if (w_cnt_inc_val == c_TIMEOUT) begin
                    w_load_rdata = 1'b1;
                    w_rdata_nxt  = '1;
                    w_set_err    = 1'b1;
                    w_state_nxt  = c_ST_DONE;
                end
            end
            c_ST_RAM_WR: begin
                ram_wr    = 1'b1;
                w_cnt_inc = 1'b1;
                if (ram_ready) begin
                    w_state_nxt = c_ST_DONE;
                end else if (w_cnt_inc_val == c_TIMEOUT) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                cpu_ack     = 1'b1;
                cpu_err     = r_err;
                w_cnt_clr   = 1'b1;
                w_state_nxt = c_ST_RELEASE;
            end
            c_ST_RELEASE: begin
                // A request still held after ack must not start a second access
                if (!cpu_rd && !cpu_wr) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_rd <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_is_rd <= cpu_rd;
            end
            if (w_load_rdata) begin
                r_rdata <= w_rdata_nxt;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= w_cnt_inc_val;
            end
            if (w_cnt_clr) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_read_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_mux
// Description : Self-checking bench for mem_read_mux (vector table, reset
//               sequence and randomized accesses against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_mux;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 12;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rom_sel;
        logic [DATA_W-1:0] rom_dat;
        int                delay;     // RAM cycle on which ready rises, 0 = never
        logic [DATA_W-1:0] ram_dat;
        int                hold;      // cycles the request stays high after ack
        int                exp_lat;
        logic [DATA_W-1:0] exp_data;
        logic              exp_err;
        int                exp_rom;
        int                exp_rd;
        int                exp_wr;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;
    logic              rom_selected;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_rd;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] model_data;
    vec_t tbl[10];

    always #5 clk = ~clk;

    mem_read_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .rom_selected(rom_selected),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic rs,
                                input logic [DATA_W-1:0] rdat, input int dly,
                                input logic [DATA_W-1:0] mdat, input int hold, input int lat,
                                input logic [DATA_W-1:0] xd, input logic xe, input int xrom,
                                input int xrd, input int xwr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rom_sel = rs;
        v.rom_dat = rdat; v.delay = dly; v.ram_dat = mdat; v.hold = hold;
        v.exp_lat = lat; v.exp_data = xd; v.exp_err = xe;
        v.exp_rom = xrom; v.exp_rd = xrd; v.exp_wr = xwr;
        return v;
    endfunction

    // Reference: ROM hit costs probe + done; RAM adds one cycle per cycle the
    // request is held, capped at TIMEOUT.
    function automatic vec_t predict(input vec_t v, input logic [DATA_W-1:0] prev);
        vec_t r;
        logic ok;
        int   n_ram;
        r     = v;
        ok    = (v.delay >= 1) && (v.delay <= TIMEOUT);
        n_ram = ok ? v.delay : TIMEOUT;
        if (v.rd && v.rom_sel) begin
            r.exp_lat = 2; r.exp_data = v.rom_dat; r.exp_err = 1'b0;
            r.exp_rom = 1; r.exp_rd = 0; r.exp_wr = 0;
        end else begin
            r.exp_lat  = 2 + n_ram;
            r.exp_err  = !ok;
            r.exp_rom  = v.rd ? 1 : 0;
            r.exp_rd   = v.rd ? n_ram : 0;
            r.exp_wr   = v.rd ? 0 : n_ram;
            r.exp_data = !v.rd ? prev : (ok ? v.ram_dat : {DATA_W{1'b1}});
        end
        return r;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        int lat, acks, n_rom, n_rd, n_wr, ram_cyc;
        logic              err_s;
        logic [DATA_W-1:0] data_s, wd;
        logic [ADDR_W-1:0] rom_a, ram_a;
        lat = 0; acks = 0; n_rom = 0; n_rd = 0; n_wr = 0; ram_cyc = 0;
        err_s = 1'b0; data_s = '0; wd = '0; rom_a = '0; ram_a = '0;
        @(negedge clk);
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (rom_rd) begin n_rom++; rom_a = rom_addr; end
            if (ram_rd) n_rd++;
            if (ram_wr) begin n_wr++; wd = ram_wdata; end
            if (ram_rd || ram_wr) ram_a = ram_addr;
            if (cpu_ack) begin
                acks++;
                if (acks == 1) begin lat = cyc; err_s = cpu_err; data_s = cpu_rdata; end
            end
            if (ram_rd || ram_wr) begin
                ram_cyc++;
                ram_ready    = (ram_cyc == v.delay);
                ram_rdata    = v.ram_dat;
                rom_selected = 1'($urandom);
            end else begin
                ram_ready    = 1'($urandom);
                ram_rdata    = 12'($urandom);
                rom_selected = v.rom_sel;
            end
            rom_data = rom_rd ? v.rom_dat : 12'($urandom);
            if (acks > 0 && cyc >= lat + v.hold) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
            if (acks > 0 && cyc >= lat + v.hold + 4) break;
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_acks"}, acks, 1);
        check({tag, "_err"}, err_s, v.exp_err);
        check({tag, "_rdata"}, data_s, v.exp_data);
        check({tag, "_rom_rd_cycles"}, n_rom, v.exp_rom);
        check({tag, "_ram_rd_cycles"}, n_rd, v.exp_rd);
        check({tag, "_ram_wr_cycles"}, n_wr, v.exp_wr);
        if (v.exp_rom > 0) check({tag, "_rom_addr"}, rom_a, v.addr);
        if (v.exp_rd + v.exp_wr > 0) check({tag, "_ram_addr"}, ram_a, v.addr);
        if (v.exp_wr > 0) check({tag, "_ram_wdata"}, wd, v.wdata);
    endtask

    initial begin
        reset = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
        rom_data = '0; rom_selected = 1'b0; ram_rdata = '0; ram_ready = 1'b0;

        //        rd wr addr       wdata     rs rom_dat   dly ram_dat  hold lat data     err rom rd  wr
        tbl[0] = mk(1, 0, 15'o07400, 12'o0,    1, 12'o7240, 0,  12'o0,    0,  2,  12'o7240, 0, 1, 0,  0);
        tbl[1] = mk(1, 0, 15'o00200, 12'o0,    0, 12'o0,    3,  12'o1234, 0,  5,  12'o1234, 0, 1, 3,  0);
        tbl[2] = mk(0, 1, 15'o07400, 12'o5555, 1, 12'o3333, 1,  12'o7070, 0,  3,  12'o1234, 0, 0, 0,  1);
        tbl[3] = mk(1, 0, 15'o00100, 12'o0,    0, 12'o0,    0,  12'o2222, 0,  17, 12'o7777, 1, 1, 15, 0);
        tbl[4] = mk(1, 0, 15'o00300, 12'o0,    0, 12'o0,    1,  12'o4321, 0,  3,  12'o4321, 0, 1, 1,  0);
        tbl[5] = mk(1, 0, 15'o07402, 12'o0,    1, 12'o0123, 0,  12'o0,    10, 2,  12'o0123, 0, 1, 0,  0);
        tbl[6] = mk(1, 0, 15'o01000, 12'o0,    0, 12'o0,    2,  12'o0707, 0,  4,  12'o0707, 0, 1, 2,  0);
        tbl[7] = mk(1, 1, 15'o07403, 12'o1111, 1, 12'o6543, 0,  12'o0,    0,  2,  12'o6543, 0, 1, 0,  0);
        tbl[8] = mk(0, 1, 15'o00050, 12'o4444, 0, 12'o0,    0,  12'o7070, 0,  17, 12'o6543, 1, 0, 0,  15);
        tbl[9] = mk(1, 0, 15'o00600, 12'o0,    0, 12'o0,    15, 12'o1111, 0,  17, 12'o1111, 0, 1, 15, 0);

        repeat (2) @(negedge clk);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_err", cpu_err, 0);
        check("rst_rom_rd", rom_rd, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a RAM read wait
        @(negedge clk);
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'o00400; rom_selected = 1'b0; ram_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_ram_rd_before", ram_rd, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_ram_rd", ram_rd, 0);
        check("midrst_rom_rd", rom_rd, 0);
        check("midrst_cpu_ack", cpu_ack, 0);
        check("midrst_cpu_rdata", cpu_rdata, 0);
        check("midrst_ram_addr", ram_addr, 0);
        cpu_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_ack", cpu_ack, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        apply_vec(mk(1, 0, 15'o07401, 12'o0, 1, 12'o1224, 0, 12'o0, 0, 2, 12'o1224, 0, 1, 0, 0),
                  "post_reset_rom");
        model_data = 12'o1224;

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int   op;
            op = int'($urandom_range(0, 2));
            v  = mk(op != 1, op != 0, 15'($urandom), 12'($urandom), 1'($urandom), 12'($urandom),
                    int'($urandom_range(0, 16)), 12'($urandom), int'($urandom_range(0, 3)),
                    0, 12'o0, 1'b0, 0, 0, 0);
            v  = predict(v, model_data);
            model_data = v.exp_data;
            apply_vec(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
